// File: rtl/button_conditioner.sv
// Push-button conditioner: per channel a 2-FF synchronizer, a counter-based
// debouncer, one-cycle press/release pulses and optional auto-repeat.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   btn_raw     raw asynchronous button levels, active high
//   btn_level   debounced button level
//   btn_press   one-cycle pulse on an accepted 0->1 change
//   btn_release one-cycle pulse on an accepted 1->0 change
//   btn_repeat  one-cycle auto-repeat pulse while held (masked channels only)
//   btn_event   btn_press | btn_repeat, registered
module button_conditioner #(
    parameter int               N_BTN        = 4,
    parameter int               DB_CNT       = 500,
    parameter int               REPEAT_DELAY = 5000000,
    parameter int               REPEAT_RATE  = 1000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK  = 4'b1100,
    parameter int               CNT_W        = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic [N_BTN-1:0] btn_event
);

    localparam int DB_W = $clog2(DB_CNT + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CNT - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [N_BTN-1:0] stable_dly_q, stable_dly_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [N_BTN-1:0] repeat_q, repeat_d;
    logic [N_BTN-1:0] event_q, event_d;
    logic [N_BTN-1:0] rpt_armed_q, rpt_armed_d;

    logic [N_BTN-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [N_BTN-1:0][CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;

    // Edges of the debounced level, seen one cycle after stable changes.
    logic [N_BTN-1:0] rise, fall;
    assign rise = stable_q & ~stable_dly_q;
    assign fall = ~stable_q & stable_dly_q;

    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        db_cnt_d     = '0;
        rpt_cnt_d    = '0;
        rpt_armed_d  = '0;
        repeat_d     = '0;
        press_d      = rise;
        release_d    = fall;

        for (int i = 0; i < N_BTN; i++) begin
            // Any agreement between input and stable level restarts the count.
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end

            // Counter is held at zero on the press cycle and whenever the
            // level is low, so no repeat can follow a release.
            if (REPEAT_MASK[i] && stable_q[i] && !rise[i]) begin
                rpt_armed_d[i] = rpt_armed_q[i];
                if (rpt_cnt_q[i] == (rpt_armed_q[i] ? RATE_LAST : DLY_LAST)) begin
                    repeat_d[i]    = 1'b1;
                    rpt_armed_d[i] = 1'b1;
                end else begin
                    rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_W'(1);
                end
            end
        end

        event_d = press_d | repeat_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            db_cnt_q     <= '0;
            rpt_cnt_q    <= '0;
            rpt_armed_q  <= '0;
            press_q      <= '0;
            release_q    <= '0;
            repeat_q     <= '0;
            event_q      <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            db_cnt_q     <= db_cnt_d;
            rpt_cnt_q    <= rpt_cnt_d;
            rpt_armed_q  <= rpt_armed_d;
            press_q      <= press_d;
            release_q    <= release_d;
            repeat_q     <= repeat_d;
            event_q      <= event_d;
        end
    end

    assign btn_level   = stable_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;
    assign btn_event   = event_q;

endmodule
